alu_operand_loader: RTL
=======================

// Module: alu_operand_loader
// PURPOSE
// Upstream feeder for the 32-bit pipelined ALU. Assembles full-width operands A and B and an opcode
// from a byte-wide valid/ready input stream, presents them stably to the ALU, issues a one-cycle
// strobe, and tracks the fixed ALU+pipeline latency to flag when the result is valid at the outputs.
// Removes the 8-bit/5-bit pin truncation so the ALU sees true 32-bit operands.
// PARAMETERS
// DATA_W   32  operand width; must be a multiple of 8; NB = DATA_W/8 bytes per operand
// OP_W     5   opcode width, taken from LSBs of the opcode byte (OP_W <= 8)
// ALU_LAT  4   cycles from issue to result valid at pipe output (1 ALU reg + 3 pipe regs); >= 1
// PORTS
// clk           in   1       clock
// rst_n         in   1       async active-low reset
// ena           in   1       global enable; when low all state, counters and outputs hold
// clr           in   1       sync abort; returns to LOAD_A (priority over byte accept)
// in_data       in   8       stream byte
// in_valid      in   1       in_data valid
// in_ready      out  1       loader can accept a byte this cycle
// alu_a         out  DATA_W  operand A to ALU
// alu_b         out  DATA_W  operand B to ALU
// alu_op        out  OP_W    opcode to ALU
// issue         out  1       one-cycle strobe: alu_a/alu_b/alu_op valid this cycle
// result_valid  out  1       one-cycle strobe: ALU pipeline output holds this op's result
// busy          out  1       high from first accepted byte until result_valid (inclusive)
// BEHAVIOUR
// - One clock, reset asynchronous active-low. Reset: state=LOAD_A, byte count 0, shadow A/B/op 0,
//   alu_a=alu_b=0, alu_op=0, issue=0, result_valid=0, busy=0, in_ready=0 during reset.
// - Accept = in_valid & in_ready & ena & !clr. in_ready = ena & state in {LOAD_A,LOAD_B,LOAD_OP}.
// - States: LOAD_A -> LOAD_B -> LOAD_OP -> ISSUE -> WAIT -> LOAD_A.
//   LOAD_A/LOAD_B: NB accepts each, little-endian (first byte -> bits [7:0]); byte counter 0..NB-1,
//     wraps to 0 on the NB-th accept and advances state.
//   LOAD_OP: one accept; shadow op = in_data[OP_W-1:0], upper bits ignored; -> ISSUE.
//   ISSUE: single cycle; alu_a/alu_b/alu_op registered from shadows on ISSUE entry, so they are valid
//     in the same cycle issue=1; outputs held unchanged until the next ISSUE; wait counter loaded
//     with ALU_LAT-1; -> WAIT.
//   WAIT: counter decrements per enabled cycle; when 0, result_valid=1 for that cycle and -> LOAD_A.
//   If issue is at enabled cycle T, result_valid is at enabled cycle T+ALU_LAT.
// - in_valid during ISSUE/WAIT is ignored (in_ready=0); no byte lost or buffered.
// - Gaps in in_valid allowed at any byte; progress only on accept.
// - ena low: nothing advances, strobes forced 0 that cycle, resume exactly where paused
//   (strobe re-asserts on the next enabled cycle in which its condition holds).
// - clr (sync, needs ena=0 or 1): state=LOAD_A, counters=0, shadows=0, issue/result_valid=0,
//   busy=0; alu_a/alu_b/alu_op keep last issued values. clr in same cycle as a would-be accept:
//   clr wins, byte dropped.
// - Async reset mid-operation: immediate return to reset values; partial operands discarded.
// - busy = (state != LOAD_A) | (byte count != 0), plus the result_valid cycle.
// TESTING
// 1 bytes 12 00 00 00 | 05 00 00 00 | 00 back-to-back -> issue 1 cycle after 9th accept, alu_a=0x12,
//   alu_b=0x05, alu_op=0; result_valid exactly 4 cycles after issue; busy drops after it.
// 2 A bytes 78 56 34 12, B bytes 01 00 00 80, op byte E3 -> alu_a=0x12345678, alu_b=0x80000001,
//   alu_op=0x03 (upper opcode bits ignored).
// 3 hold in_valid=1 continuously with 18 bytes queued -> in_ready=0 during ISSUE and 4 WAIT cycles,
//   second op issues only after result_valid; no byte skipped.
// 4 drop ena for 3 cycles mid-LOAD_B and mid-WAIT -> no accepts, counter frozen, result_valid delayed
//   by exactly 3 cycles; operands unchanged.
// 5 clr after 2 B bytes -> in LOAD_A, busy=0, alu_a/alu_b still hold prior issued values;
//   next full 9-byte frame issues correctly.
// 6 rst_n low for 1 cycle during WAIT -> all outputs 0 immediately, no result_valid for aborted op.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Byte-stream feeder for the pipelined ALU: assembles little-endian operands A/B plus an opcode,
// strobes them into the ALU and counts the fixed pipeline latency until the result is valid.
module alu_operand_loader #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int ALU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              issue,
  output logic              result_valid,
  output logic              busy
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int WC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);
  localparam logic [WC_W-1:0] WAIT_INIT = WC_W'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e            state_q,    state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] shadow_a_q, shadow_a_d;
  logic [DATA_W-1:0] shadow_b_q, shadow_b_d;
  logic [OP_W-1:0]   shadow_op_q, shadow_op_d;
  logic [DATA_W-1:0] alu_a_q,    alu_a_d;
  logic [DATA_W-1:0] alu_b_q,    alu_b_d;
  logic [OP_W-1:0]   alu_op_q,   alu_op_d;

  logic in_load;
  logic accept;
  logic last_byte;

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

  // in_ready is gated by rst_n so the source never sees a handshake while reset is held.
  assign in_load      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_LOAD_OP);
  assign in_ready     = rst_n & ena & in_load;
  assign accept       = in_valid & in_ready & ~clr;
  assign last_byte    = (byte_cnt_q == LAST_BYTE);
  assign issue        = ena & ~clr & (state_q == S_ISSUE);
  assign result_valid = ena & ~clr & (state_q == S_WAIT) & (wait_cnt_q == '0);
  assign busy         = (state_q != S_LOAD_A) | (byte_cnt_q != '0);

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    shadow_a_d  = shadow_a_q;
    shadow_b_d  = shadow_b_q;
    shadow_op_d = shadow_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;

    if (clr) begin
      state_d     = S_LOAD_A;
      byte_cnt_d  = '0;
      wait_cnt_d  = '0;
      shadow_a_d  = '0;
      shadow_b_d  = '0;
      shadow_op_d = '0;
    end else if (ena) begin
      unique case (state_q)
        S_LOAD_A: if (accept) begin
          shadow_a_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
          if (last_byte) state_d = S_LOAD_B;
        end
        S_LOAD_B: if (accept) begin
          shadow_b_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
          if (last_byte) state_d = S_LOAD_OP;
        end
        S_LOAD_OP: if (accept) begin
          // Operands are captured on the way into ISSUE so they are already stable when issue fires.
          shadow_op_d = in_data[OP_W-1:0];
          alu_a_d     = shadow_a_q;
          alu_b_d     = shadow_b_q;
          alu_op_d    = in_data[OP_W-1:0];
          state_d     = S_ISSUE;
        end
        S_ISSUE: begin
          wait_cnt_d = WAIT_INIT;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) state_d = S_LOAD_A;
          else                  wait_cnt_d = wait_cnt_q - 1'b1;
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      shadow_a_q  <= '0;
      shadow_b_q  <= '0;
      shadow_op_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      shadow_op_q <= shadow_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

endmodule
